// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART byte transmitter among NUM_SRC producers.
// A grant is held for a whole packet; a stalled owner is evicted after HOLD_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int NUM_SRC      = 2,
    parameter int START_WAIT   = 4,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_busy,
    input  logic [NUM_SRC-1:0]   err_clear,
    output logic [NUM_SRC-1:0]   err,
    output logic [1:0]           grant_id,
    output logic                 locked
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [1:0]           grant_r, last_grant_r, cand_s;
    logic                 locked_r, tx_valid_r;
    logic [7:0]           tx_data_r, hold_cnt_r, start_cnt_r, cand_data_s;
    logic [NUM_SRC-1:0]   err_r, ready_s, evict_mask_s;
    logic [2:0]           rr_s;
    logic                 own_valid_s, cand_ok_s, cand_last_s, accept_s, evict_s, hold_inc_s;

    // First requester after 'last' in circular order; bit 2 flags that one was found.
    function automatic logic [2:0] rr_pick(input logic [NUM_SRC-1:0] req, input logic [1:0] last);
        logic [2:0] res;
        res = 3'b000;
        for (int k = NUM_SRC; k >= 1; k--) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (req[i] && (2'(i) == 2'((int'(last) + k) % NUM_SRC))) begin
                    res = {1'b1, 2'(i)};
                end else begin
                    res = res;
                end
            end
        end
        return res;
    endfunction

    // Candidate selection, one-hot ready, accept and eviction decisions
    always_comb begin
        rr_s         = rr_pick(src_valid, last_grant_r);
        own_valid_s  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            own_valid_s = own_valid_s | (src_valid[i] & (2'(i) == grant_r));
        end
        if (locked_r) begin
            cand_s    = grant_r;
            cand_ok_s = own_valid_s;
        end else begin
            cand_s    = rr_s[1:0];
            cand_ok_s = rr_s[2];
        end
        accept_s     = (state_r == IDLE) && !tx_busy && cand_ok_s && !reset;
        cand_data_s  = 8'h00;
        cand_last_s  = 1'b0;
        ready_s      = '0;
        evict_mask_s = '0;
        hold_inc_s   = (state_r == IDLE) && locked_r && !own_valid_s;
        evict_s      = hold_inc_s && ((hold_cnt_r + 8'd1) == 8'(HOLD_TIMEOUT));
        for (int i = 0; i < NUM_SRC; i++) begin
            ready_s[i]      = accept_s && (2'(i) == cand_s);
            cand_data_s     = cand_data_s | (src_data[8*i +: 8] & {8{2'(i) == cand_s}});
            cand_last_s     = cand_last_s | (src_last[i] & (2'(i) == cand_s));
            evict_mask_s[i] = evict_s && (2'(i) == grant_r);
        end
    end

    // Next-state logic; WAIT_START gives up on busy after START_WAIT extra cycles
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = ISSUE;
                else          state_s = IDLE;
            end
            ISSUE: state_s = WAIT_START;
            WAIT_START: begin
                if (tx_busy || (start_cnt_r == 8'(START_WAIT))) state_s = WAIT_DONE;
                else                                            state_s = WAIT_START;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_s = IDLE;
                else          state_s = WAIT_DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, captured byte, grant bookkeeping, counters and sticky errors
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            locked_r     <= 1'b0;
            grant_r      <= 2'd0;
            last_grant_r <= 2'(NUM_SRC - 1);
            hold_cnt_r   <= 8'd0;
            start_cnt_r  <= 8'd0;
            err_r        <= '0;
        end else begin
            state_r    <= state_s;
            tx_valid_r <= accept_s;
            if (accept_s) begin
                tx_data_r  <= cand_data_s;
                grant_r    <= cand_s;
                locked_r   <= !cand_last_s;
                hold_cnt_r <= 8'd0;
                if (cand_last_s) last_grant_r <= cand_s;
            end else if (evict_s) begin
                locked_r     <= 1'b0;
                last_grant_r <= grant_r;
                hold_cnt_r   <= 8'd0;
            end else if (hold_inc_s && (hold_cnt_r != 8'hFF)) begin
                hold_cnt_r <= hold_cnt_r + 8'd1;
            end
            if ((state_r == WAIT_START) && (start_cnt_r != 8'hFF)) start_cnt_r <= start_cnt_r + 8'd1;
            else if (state_r != WAIT_START)                         start_cnt_r <= 8'd0;
            // A new eviction outranks a clear arriving in the same cycle.
            err_r <= (err_r & ~err_clear) | evict_mask_s;
        end
    end

    assign src_ready     = ready_s;
    assign tx_data       = tx_data_r;
    assign tx_data_valid = tx_valid_r;
    assign err           = err_r;
    assign grant_id      = grant_r;
    assign locked        = locked_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets, a UART busy model and a pulse monitor.
module tb_uart_tx_arbiter;
    localparam int N = 2, SW = 4, HT = 8;

    logic clk = 1'b0;
    logic reset;
    logic [1:0]  src_valid, src_last, src_ready, err_clear, err, grant_id;
    logic [15:0] src_data;
    logic [7:0]  tx_data;
    logic        tx_data_valid, tx_busy, locked;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_SRC(N), .START_WAIT(SW), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
        .src_last(src_last), .src_ready(src_ready), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .err_clear(err_clear),
        .err(err), .grant_id(grant_id), .locked(locked)
    );

    int tests = 0, fails = 0, cyc = 0;
    logic [8:0] q0[$], q1[$];
    logic [9:0] exp_q[$];
    int pulse_cyc[$];
    int busy_len = 10, busy_cnt = 0, drop_cyc = 0, acc_cyc = -1;
    logic clr_hold = 1'b0, clr_pulse = 1'b0, r0_leak = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // UART model plus source driver, both updated on the falling edge
    initial begin
        src_valid = '0; src_data = '0; src_last = '0; tx_busy = 1'b0; err_clear = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                busy_cnt = 0; tx_busy = 1'b0;
            end else if (tx_data_valid && busy_len > 0) begin
                tx_busy = 1'b1; busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin tx_busy = 1'b0; drop_cyc = cyc; end
            end
            err_clear = {1'b0, (clr_hold & locked) | clr_pulse};
            src_valid[0] = q0.size() > 0;
            if (q0.size() > 0) {src_last[0], src_data[7:0]} = q0[0];
            else begin src_last[0] = 1'b0; src_data[7:0] = 8'h00; end
            src_valid[1] = q1.size() > 0;
            if (q1.size() > 0) {src_last[1], src_data[15:8]} = q1[0];
            else begin src_last[1] = 1'b0; src_data[15:8] = 8'h00; end
            #1;
            if (src_ready[0] && src_valid[0]) begin void'(q0.pop_front()); acc_cyc = cyc + 1; end
            if (src_ready[1] && src_valid[1]) begin void'(q1.pop_front()); acc_cyc = cyc + 1; end
            if (locked && grant_id == 2'd1 && src_ready[0]) r0_leak = 1'b1;
        end
    end

    // Monitor: every issue pulse is matched against the scoreboard
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk); #2;
            if (tx_data_valid === 1'b1) begin
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_pulse: got tx_data %0h, expected no pulse", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e[7:0]));
                    check("pulse_grant_id", 32'(grant_id), 32'(e[9:8]));
                    check("accept_to_pulse", 32'(cyc), 32'(acc_cyc));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time expired, expected completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (((q0.size() + q1.size() + exp_q.size()) != 0 || tx_busy) && t < 2000) begin
            tick(1); t++;
        end
        if (t >= 2000) begin
            tests++; fails++;
            $display("FAIL %s_timeout: %0d bytes pending, expected 0", name, exp_q.size());
        end
        tick(SW + 6);
    endtask

    task automatic wait_locked(input string name);
        int t = 0;
        while (!locked && t < 100) begin tick(1); t++; end
        check({name, "_locked"}, 32'(locked), 32'd1);
    endtask

    task automatic wait_err0(input string name);
        int t = 0;
        while (!err[0] && t < 200) begin tick(1); t++; end
        check({name, "_err_set"}, 32'(err[0]), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        q0.push_back({1'b1, 8'h77});
        tick(3);
        check("reset_src_ready", 32'(src_ready), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'h00);
        check("reset_tx_valid", 32'(tx_data_valid), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_grant_id", 32'(grant_id), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        q0.delete();
        tick(1);
        reset = 1'b0;
        tick(1);

        // single byte
        q0.push_back({1'b1, 8'h41}); exp_q.push_back({2'd0, 8'h41});
        drain("single");
        check("single_locked", 32'(locked), 32'd0);
        check("single_grant_id", 32'(grant_id), 32'd0);

        // round robin from a fresh reset
        do_reset();
        q0.push_back({1'b1, 8'hA0}); q0.push_back({1'b1, 8'hA0});
        q1.push_back({1'b1, 8'hB0}); q1.push_back({1'b1, 8'hB0});
        exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd1, 8'hB0});
        exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd1, 8'hB0});
        drain("round_robin");

        // packet lock: source 0 stalls behind source 1's three-byte packet
        r0_leak = 1'b0;
        q1.push_back({1'b0, 8'h11}); q1.push_back({1'b0, 8'h12}); q1.push_back({1'b1, 8'h13});
        exp_q.push_back({2'd1, 8'h11}); exp_q.push_back({2'd1, 8'h12});
        exp_q.push_back({2'd1, 8'h13}); exp_q.push_back({2'd0, 8'h55});
        wait_locked("lock");
        q0.push_back({1'b1, 8'h55});
        drain("lock");
        check("lock_ready0_leak", 32'(r0_leak), 32'd0);

        // hold timeout evicts source 0, source 1 then proceeds
        q0.push_back({1'b0, 8'h20}); exp_q.push_back({2'd0, 8'h20});
        wait_locked("hold");
        q1.push_back({1'b1, 8'h30}); exp_q.push_back({2'd1, 8'h30});
        wait_err0("hold");
        check("hold_evict_delay", 32'(cyc - drop_cyc), 32'd9);
        check("hold_unlocked", 32'(locked), 32'd0);
        clr_pulse = 1'b1; tick(1); clr_pulse = 1'b0;
        check("err_clear", 32'(err), 32'd0);
        drain("hold");

        // clear asserted during the eviction cycle loses to the set
        clr_hold = 1'b1;
        q0.push_back({1'b0, 8'h21}); exp_q.push_back({2'd0, 8'h21});
        wait_err0("set_wins");
        tick(2);
        check("set_wins_err", 32'(err), 32'd1);
        clr_hold = 1'b0;
        drain("set_wins");

        // transmitter never raises busy
        busy_len = 0;
        pulse_cyc.delete();
        q0.push_back({1'b1, 8'hC1}); q0.push_back({1'b1, 8'hC2}); q0.push_back({1'b1, 8'hC3});
        exp_q.push_back({2'd0, 8'hC1}); exp_q.push_back({2'd0, 8'hC2}); exp_q.push_back({2'd0, 8'hC3});
        drain("no_busy");
        check("no_busy_pulses", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_cyc.size() == 3) begin
            check("no_busy_spacing1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(4 + SW));
            check("no_busy_spacing2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'(4 + SW));
        end
        busy_len = 10;

        // reset while the first byte of a packet is in WAIT_DONE
        q0.push_back({1'b0, 8'hD1}); q0.push_back({1'b0, 8'hD2}); q0.push_back({1'b1, 8'hD3});
        exp_q.push_back({2'd0, 8'hD1});
        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 100) begin tick(1); t++; end
            check("midreset_first_byte", 32'(exp_q.size()), 32'd0);
        end
        tick(4);
        q0.delete();
        pulse_cyc.delete();
        reset = 1'b1;
        tick(2);
        check("midreset_src_ready", 32'(src_ready), 32'd0);
        check("midreset_tx_valid", 32'(tx_data_valid), 32'd0);
        check("midreset_tx_data", 32'(tx_data), 32'h00);
        check("midreset_locked", 32'(locked), 32'd0);
        check("midreset_grant_id", 32'(grant_id), 32'd0);
        check("midreset_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick(15);
        check("midreset_no_pulse", 32'(pulse_cyc.size()), 32'd0);
        q0.push_back({1'b1, 8'hE0}); q1.push_back({1'b1, 8'hE1});
        exp_q.push_back({2'd0, 8'hE0}); exp_q.push_back({2'd1, 8'hE1});
        drain("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
